// File: rtl/oscilo_pkg.sv
// rtl/oscilo_pkg.sv - shared constants and state encoding for the oscilloscope capture path
package oscilo_pkg;

  // First byte of every frame so the host can find frame boundaries
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HEADER   = 3'd1,
    S_LENGTH   = 3'd2,
    S_READ     = 3'd3,
    S_SEND     = 3'd4,
    S_WAIT     = 3'd5,
    S_CHECKSUM = 3'd6,
    S_FINISH   = 3'd7
  } sr_state_t;

  // Length field carries (count-1) so a full 256-sample frame still fits in one byte
  function automatic logic [7:0] length_byte(input int count);
    return 8'((count - 1) % 256);
  endfunction

endpackage

// File: rtl/sample_reader.sv
// rtl/sample_reader.sv - streams one framed block of memory samples to the UART transmitter
module sample_reader
  import oscilo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_COUNT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_oe,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done
);

  localparam logic [7:0]            LEN_BYTE  = length_byte(SAMPLE_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_COUNT - 1);

  sr_state_t             state;
  // Remembers which byte WAIT is waiting on, so one WAIT state serves the whole frame
  sr_state_t             ret_state;
  logic [ADDR_WIDTH-1:0] counter;
  logic [7:0]            sum;
  logic [DATA_WIDTH-1:0] data_reg;

  // Memory read port: address always follows the counter, enable only while reading
  always_comb begin
    mem_addr = counter;
    mem_oe   = (state == S_READ);
  end

  // Frame sequencer: header, length, samples, checksum, with abort on activate loss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      counter   <= '0;
      sum       <= '0;
      data_reg  <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // tx_start is a single-cycle pulse; every issue below re-arms it for one cycle only
      tx_start <= 1'b0;
      if (!activate && state != S_IDLE && state != S_FINISH) begin
        // A byte already handed to the UART finishes by itself; nothing new is started
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (activate) begin
              counter <= '0;
              sum     <= '0;
              state   <= S_HEADER;
            end
          end
          S_HEADER: begin
            if (!tx_active) begin
              tx_data   <= SYNC_BYTE;
              tx_start  <= 1'b1;
              ret_state <= S_HEADER;
              state     <= S_WAIT;
            end
          end
          S_LENGTH: begin
            if (!tx_active) begin
              tx_data   <= LEN_BYTE;
              tx_start  <= 1'b1;
              ret_state <= S_LENGTH;
              state     <= S_WAIT;
            end
          end
          S_READ: begin
            data_reg <= mem_data;
            sum      <= sum + mem_data[7:0];
            state    <= S_SEND;
          end
          S_SEND: begin
            if (!tx_active) begin
              tx_data   <= data_reg[7:0];
              tx_start  <= 1'b1;
              ret_state <= S_SEND;
              state     <= S_WAIT;
            end
          end
          S_CHECKSUM: begin
            if (!tx_active) begin
              tx_data   <= sum;
              tx_start  <= 1'b1;
              ret_state <= S_CHECKSUM;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (tx_done) begin
              case (ret_state)
                S_HEADER: state <= S_LENGTH;
                S_LENGTH: state <= S_READ;
                S_SEND: begin
                  if (counter == LAST_ADDR) begin
                    state <= S_CHECKSUM;
                  end else begin
                    counter <= counter + ADDR_WIDTH'(1);
                    state   <= S_READ;
                  end
                end
                S_CHECKSUM: begin
                  done  <= 1'b1;
                  state <= S_FINISH;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
          S_FINISH: begin
            if (!activate) begin
              done  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_reader.sv
// tb/tb_sample_reader.sv - directed frame checks of sample_reader against a UART transmitter model
module tb_sample_reader;
  import oscilo_pkg::*;

  localparam int BYTE_CYC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic act_a, act_b, act_c;
  logic tx_active = 1'b0;
  logic tx_done   = 1'b0;

  logic       done_a, done_b, done_c;
  logic       oe_a, oe_b, oe_c;
  logic       start_a, start_b, start_c;
  logic [7:0] addr_a, addr_b, addr_c;
  logic [7:0] txd_a, txd_b, txd_c;
  logic [7:0] data_a, data_b, data_c;

  logic [7:0] smp [0:255];
  assign data_a = addr_a;
  assign data_b = smp[addr_b];
  assign data_c = smp[addr_c];

  sample_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .SAMPLE_COUNT(256)) dut_a (
    .clk(clk), .reset(reset), .activate(act_a), .done(done_a),
    .mem_addr(addr_a), .mem_data(data_a), .mem_oe(oe_a),
    .tx_data(txd_a), .tx_start(start_a), .tx_active(tx_active), .tx_done(tx_done));

  sample_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .SAMPLE_COUNT(4)) dut_b (
    .clk(clk), .reset(reset), .activate(act_b), .done(done_b),
    .mem_addr(addr_b), .mem_data(data_b), .mem_oe(oe_b),
    .tx_data(txd_b), .tx_start(start_b), .tx_active(tx_active), .tx_done(tx_done));

  sample_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .SAMPLE_COUNT(1)) dut_c (
    .clk(clk), .reset(reset), .activate(act_c), .done(done_c),
    .mem_addr(addr_c), .mem_data(data_c), .mem_oe(oe_c),
    .tx_data(txd_c), .tx_start(start_c), .tx_active(tx_active), .tx_done(tx_done));

  int         sel = 0;
  logic       start_m, done_m, oe_m;
  logic [7:0] txd_m, addr_m;
  assign start_m = (sel == 0) ? start_a : (sel == 1) ? start_b : start_c;
  assign done_m  = (sel == 0) ? done_a  : (sel == 1) ? done_b  : done_c;
  assign oe_m    = (sel == 0) ? oe_a    : (sel == 1) ? oe_b    : oe_c;
  assign txd_m   = (sel == 0) ? txd_a   : (sel == 1) ? txd_b   : txd_c;
  assign addr_m  = (sel == 0) ? addr_a  : (sel == 1) ? addr_b  : addr_c;

  int         total = 0;
  int         bad = 0;
  int         viol = 0;
  int         extra = 0;
  int         busy = 0;
  int         hold = 0;
  bit         prev_start = 1'b0;
  bit         stab = 1'b0;
  bit         spur_idle = 1'b0;
  bit         spur_read = 1'b0;
  logic [7:0] cur = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // UART transmitter model, evaluated on the falling edge
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (reset) stab = 1'b0;
    if (stab && txd_m !== cur) viol++;
    if (start_m === 1'b1) begin
      if (tx_active) viol++;
      if (prev_start) viol++;
      rx_q.push_back(txd_m);
      cur       = txd_m;
      stab      = 1'b1;
      busy      = BYTE_CYC;
      hold      = 0;
      tx_active = 1'b1;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        tx_done   = 1'b1;
        stab      = 1'b0;
        hold      = extra;
        tx_active = (extra != 0);
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) tx_active = 1'b0;
    end
    if (spur_idle) begin
      tx_done   = 1'b1;
      spur_idle = 1'b0;
    end
    if (spur_read && oe_m === 1'b1) begin
      tx_done   = 1'b1;
      spur_read = 1'b0;
    end
    prev_start = (start_m === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic make_exp(input logic [7:0] len, input int n, input logic [7:0] cks);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(len);
    for (int i = 0; i < n; i++) exp_q.push_back(smp[i]);
    exp_q.push_back(cks);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_m !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done_m, 1'b1);
  endtask

  task automatic wait_bytes(input string tag, input int cnt, input int budget);
    int n = 0;
    while (rx_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach"}, (rx_q.size() >= cnt), 1'b1);
  endtask

  task automatic release_all();
    act_a = 1'b0;
    act_b = 1'b0;
    act_c = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    act_a = 1'b0;
    act_b = 1'b0;
    act_c = 1'b0;
    for (int i = 0; i < 256; i++) smp[i] = 8'(i);
    repeat (3) @(negedge clk);

    chk("rst_done", done_a, 1'b0);
    chk("rst_start", start_a, 1'b0);
    chk("rst_txdata", txd_a, 8'h00);
    chk("rst_oe", oe_a, 1'b0);
    chk("rst_addr", addr_a, 8'h00);
    chk("rst_state", 32'(dut_a.state), 32'(S_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full 256-sample frame, identity memory
    sel = 0;
    make_exp(8'hFF, 256, 8'h80);
    rx_q.delete();
    act_a = 1'b1;
    wait_done("t1", 6000);
    check_frame("t1");
    act_a = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_done_clr", done_a, 1'b0);
    release_all();

    // All-ones memory, four samples, checksum wraps
    sel = 1;
    for (int i = 0; i < 4; i++) smp[i] = 8'hFF;
    make_exp(8'h03, 4, 8'hFC);
    rx_q.delete();
    act_b = 1'b1;
    wait_done("t2", 1000);
    check_frame("t2");
    release_all();

    // Slow transmitter: busy for 50 extra cycles after every byte
    extra = 50;
    smp[0] = 8'h01; smp[1] = 8'h02; smp[2] = 8'h03; smp[3] = 8'h04;
    make_exp(8'h03, 4, 8'h0A);
    rx_q.delete();
    act_b = 1'b1;
    wait_done("t3", 3000);
    check_frame("t3");
    extra = 0;
    release_all();

    // Abort after the third sample's start, then a complete frame
    smp[0] = 8'h10; smp[1] = 8'h20; smp[2] = 8'h30; smp[3] = 8'h40;
    rx_q.delete();
    act_b = 1'b1;
    wait_bytes("t4", 5, 1000);
    act_b = 1'b0;
    repeat (30) @(negedge clk);
    chk("t4_count", rx_q.size(), 5);
    chk("t4_done", done_b, 1'b0);
    chk("t4_state", 32'(dut_b.state), 32'(S_IDLE));
    chk("t4_oe", oe_b, 1'b0);
    make_exp(8'h03, 4, 8'hA0);
    rx_q.delete();
    act_b = 1'b1;
    wait_done("t4r", 1000);
    check_frame("t4r");
    release_all();

    // Reset while waiting on the second sample
    rx_q.delete();
    act_b = 1'b1;
    wait_bytes("t5", 4, 1000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_done", done_b, 1'b0);
    chk("t5_start", start_b, 1'b0);
    chk("t5_txdata", txd_b, 8'h00);
    chk("t5_oe", oe_b, 1'b0);
    chk("t5_addr", addr_b, 8'h00);
    repeat (10) @(negedge clk);
    rx_q.delete();
    reset = 1'b0;
    wait_done("t5r", 1000);
    check_frame("t5r");
    release_all();

    // Stray tx_done in IDLE and during READ
    smp[0] = 8'h05; smp[1] = 8'h06; smp[2] = 8'h07; smp[3] = 8'h08;
    rx_q.delete();
    spur_idle = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_bytes", rx_q.size(), 0);
    chk("t6_idle_state", 32'(dut_b.state), 32'(S_IDLE));
    spur_read = 1'b1;
    make_exp(8'h03, 4, 8'h1A);
    act_b = 1'b1;
    wait_done("t6", 1000);
    check_frame("t6");
    chk("t6_injected", spur_read, 1'b0);
    release_all();

    // Single-sample frame: sample and checksum are the same byte
    sel = 2;
    smp[0] = 8'h3C;
    make_exp(8'h00, 1, 8'h3C);
    rx_q.delete();
    act_c = 1'b1;
    wait_done("t7", 500);
    check_frame("t7");
    release_all();

    chk("protocol_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_reader.md
SAMPLE_READER -- requirements
Module: sample_reader

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, sample width in bits.
REQ-002 SHALL have parameter: ADDR_WIDTH, 8, sample memory address width.
REQ-003 SHALL have parameter: SAMPLE_COUNT, 256, number of samples sent per frame, range 1..2**ADDR_WIDTH.
REQ-004 clk  input  1  single system clock; one clock domain; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 activate  input  1  level request from the state watcher; high for the whole job.
REQ-007 done  output  1  level; high when the frame is fully sent.
REQ-008 mem_addr  output  ADDR_WIDTH  read address into sample memory; memory has an asynchronous read port.
REQ-009 mem_data  input  DATA_WIDTH  read data from sample memory.
REQ-010 mem_oe  output  1  sample memory output enable.
REQ-011 tx_data  output  8  byte to the UART transmitter.
REQ-012 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-013 tx_active  input  1  UART transmitter busy.
REQ-014 tx_done  input  1  one-cycle pulse when the UART transmitter finishes a byte.

Function
REQ-015 SHALL send a frame in this order: SYNC byte 0xA5; length byte (SAMPLE_COUNT-1) mod 256; samples from address 0 up to SAMPLE_COUNT-1; checksum byte.
REQ-016 Checksum SHALL be the 8-bit sum of all sample bytes mod 256; the sum register clears on entry to HEADER and ignores carry-out.
REQ-017 FSM states SHALL be IDLE, HEADER, LENGTH, READ, SEND, WAIT, CHECKSUM, FINISH.
REQ-018 IDLE: when activate is high, go to HEADER on the next cycle and reset the address counter to 0.
REQ-019 HEADER/LENGTH/CHECKSUM: when tx_active is low, load tx_data and pulse tx_start for exactly one cycle, then go to WAIT.
REQ-020 READ: drive mem_addr = counter with mem_oe high, register mem_data into the data register at the end of the cycle, add it to the sum, then go to SEND. Sample latency from address to data register is 1 cycle.
REQ-021 SEND: apply the same start rule as REQ-019, using the registered sample byte.
REQ-022 WAIT: hold until tx_done. Then go to LENGTH after HEADER, or READ after LENGTH.
REQ-023 WAIT after a sample: if counter == SAMPLE_COUNT-1, go to CHECKSUM; otherwise increment the counter and go to READ.
REQ-024 WAIT after the checksum: go to FINISH.
REQ-025 tx_start SHALL never assert while tx_active is high, and SHALL never assert on two consecutive cycles.
REQ-026 tx_data SHALL stay stable from the tx_start cycle until tx_done.
REQ-027 FINISH: hold done high while activate is high; when activate falls, clear done and return to IDLE.
REQ-028 If activate falls in any state other than IDLE or FINISH, SHALL abort to IDLE on the next cycle with no further tx_start; a byte already started completes on its own.
REQ-029 tx_done arriving in any state other than WAIT SHALL be ignored.
REQ-030 A new activate after FINISH→IDLE SHALL restart the frame from SYNC with the sum cleared.
REQ-031 mem_oe SHALL be low outside READ. mem_addr SHALL hold the counter value at all times.
REQ-032 With SAMPLE_COUNT=1, the frame SHALL be A5, 00, s0, s0.

Reset
REQ-033 While reset is high, state SHALL be IDLE and outputs SHALL be: done=0, tx_start=0, tx_data=0, mem_oe=0, mem_addr=0.
REQ-034 While reset is high, the counter, sum and data register SHALL be 0, taking effect asynchronously.
REQ-035 Reset during a frame SHALL discard the frame; after release the block waits for activate.

Structure
REQ-036 Shared package oscilo_pkg SHALL hold the SYNC byte constant (8'hA5) and the sample_reader state enum.
REQ-037 No sub-module is required: counter, checksum and FSM stay in one module. The UART transmitter and sample RAM are existing external instances.

Verification
REQ-038 Memory preloaded with addr i → i, SAMPLE_COUNT=256, activate held → UART bytes A5, FF, 00..FF, 80. Then done=1; activate low → done=0 next cycle.
REQ-039 Memory all 0xFF, SAMPLE_COUNT=4 → bytes A5, 03, FF, FF, FF, FF, FC.
REQ-040 Transmitter model with tx_active held high 50 extra cycles after each tx_done → no tx_start while busy; frame content unchanged.
REQ-041 activate dropped after the 3rd sample's tx_start → no further tx_start, state IDLE, done stays 0; re-activate → full frame from A5.
REQ-042 Reset pulsed mid-frame (during WAIT) → all outputs 0 immediately; after release with activate high, a fresh frame starts from A5.
REQ-043 Spurious tx_done pulse injected in IDLE and in READ → ignored; byte count and checksum correct.
